// File: rtl/misao_pkg.sv
// Shared types and constants for the MISA-O instruction fetch path.
package misao_pkg;

    localparam int ADDR_W = 15;

    typedef logic [ADDR_W:0] nib_addr_t;
    typedef logic [7:0]      byte_t;
    typedef logic [3:0]      nibble_t;

    // Nibble address the core starts executing from after reset.
    localparam nib_addr_t RESET_VECTOR = '0;

    function automatic nibble_t select_nibble(input byte_t b, input logic hi);
        return hi ? b[7:4] : b[3:0];
    endfunction

endpackage

// File: rtl/misao_byte_fifo.sv
// Byte FIFO holding prefetched instruction bytes; flush empties it in one edge.
module misao_byte_fifo
    import misao_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  byte_t            wdata,
    output byte_t            rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    byte_t            storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = storage[rd_ptr];

    // Data array carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy update; flush discards everything queued.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/misao_fetch_queue.sv
// Instruction prefetch queue: byte fetch from the shared memory port, nibble
// delivery to the decoder, and redirect handling for branches and jumps.
module misao_fetch_queue
    import misao_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter int  ADDR_W = misao_pkg::ADDR_W,
    localparam int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_enable_read,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data_in,
    input  logic              bus_busy,
    input  logic              redirect,
    input  logic [ADDR_W:0]   redirect_addr,
    output logic              nib_valid,
    output logic [3:0]        nib_data,
    output logic [ADDR_W:0]   nib_addr,
    input  logic              nib_ready,
    output logic [LVL_W-1:0]  level
);

    logic [ADDR_W-1:0] fetch_addr;
    logic [ADDR_W-1:0] head_addr;
    logic              sel;

    byte_t             head_byte;
    logic [LVL_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              consume;
    logic              pop;

    // A full queue blocks fetch even when a byte leaves in the same cycle.
    assign mem_enable_read = !rst && !redirect && !bus_busy && !fifo_full;
    assign consume         = !rst && !redirect && !fifo_empty && nib_ready;
    assign pop             = consume && sel;

    assign mem_addr  = fetch_addr;
    assign nib_valid = !fifo_empty;
    assign nib_data  = fifo_empty ? 4'h0 : select_nibble(head_byte, sel);
    assign nib_addr  = {head_addr, sel};
    assign level     = fifo_count;

    misao_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (mem_enable_read),
        .pop   (pop),
        .wdata (mem_data_in),
        .rdata (head_byte),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Address and nibble-select tracking; reset behaves as a redirect to the
    // reset vector, and an odd target starts on the high nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr <= ADDR_W'(RESET_VECTOR >> 1);
            head_addr  <= ADDR_W'(RESET_VECTOR >> 1);
            sel        <= RESET_VECTOR[0];
        end else if (redirect) begin
            fetch_addr <= redirect_addr[ADDR_W:1];
            head_addr  <= redirect_addr[ADDR_W:1];
            sel        <= redirect_addr[0];
        end else begin
            if (mem_enable_read) begin
                fetch_addr <= fetch_addr + 1'b1;
            end
            if (consume) begin
                sel <= !sel;
                if (sel) begin
                    head_addr <= head_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_misao_fetch_queue.sv
// Self-checking bench for misao_fetch_queue with a queue-based reference model.
module tb_misao_fetch_queue;
    import misao_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_enable_read;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data_in;
    logic          bus_busy;
    logic          redirect;
    logic [AW:0]   redirect_addr;
    logic          nib_valid;
    logic [3:0]    nib_data;
    logic [AW:0]   nib_addr;
    logic          nib_ready;
    logic [2:0]    level;

    logic [7:0]    mem [0:32767];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte queue plus head nibble position and fetch pointer.
    byte_t         m_q[$];
    logic [AW-1:0] m_fetch;
    logic [AW-1:0] m_head;
    logic          m_sel;

    always #5 clk = ~clk;

    assign mem_data_in = mem[mem_addr];

    misao_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_enable_read (mem_enable_read),
        .mem_addr        (mem_addr),
        .mem_data_in     (mem_data_in),
        .bus_busy        (bus_busy),
        .redirect        (redirect),
        .redirect_addr   (redirect_addr),
        .nib_valid       (nib_valid),
        .nib_data        (nib_data),
        .nib_addr        (nib_addr),
        .nib_ready       (nib_ready),
        .level           (level)
    );

    function automatic logic m_valid();
        return m_q.size() != 0;
    endfunction

    function automatic logic [3:0] m_data();
        if (m_q.size() == 0) return 4'h0;
        return m_sel ? m_q[0][7:4] : m_q[0][3:0];
    endfunction

    function automatic logic m_fetch_en();
        return !rst && !redirect && !bus_busy && (m_q.size() < DEPTH);
    endfunction

    function automatic logic [3:0] mem_nib(input int nib_a);
        logic [7:0] b;
        b = mem[(nib_a >> 1) & 32'h7FFF];
        return (nib_a % 2 == 1) ? b[7:4] : b[3:0];
    endfunction

    task automatic settle();
        #1;
    endtask

    // Advance one clock edge, updating the model from the inputs in force.
    task automatic tick();
        logic  en;
        logic  cons;
        byte_t b;
        en   = m_fetch_en();
        cons = m_valid() && nib_ready && !redirect && !rst;
        b    = mem[m_fetch];
        @(posedge clk);
        if (rst) begin
            m_q.delete(); m_fetch = '0; m_head = '0; m_sel = 1'b0;
        end else if (redirect) begin
            m_q.delete();
            m_fetch = redirect_addr[AW:1];
            m_head  = redirect_addr[AW:1];
            m_sel   = redirect_addr[0];
        end else begin
            if (cons) begin
                if (m_sel) begin
                    void'(m_q.pop_front());
                    m_head = m_head + 1'b1;
                    m_sel  = 1'b0;
                end else begin
                    m_sel = 1'b1;
                end
            end
            if (en) begin
                m_q.push_back(b);
                m_fetch = m_fetch + 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect = 1'b0; bus_busy = 1'b0; nib_ready = 1'b0; redirect_addr = '0;
        tick(); tick(); settle();
        n_checks++; if (mem_enable_read !== 1'b0) begin n_errors++; $display("FAIL reset_en got %b want 0", mem_enable_read); end
        n_checks++; if (mem_addr !== 15'h0) begin n_errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_checks++; if (nib_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", nib_valid); end
        n_checks++; if (nib_data !== 4'h0) begin n_errors++; $display("FAIL reset_data got %h want 0", nib_data); end
        n_checks++; if (nib_addr !== 16'h0) begin n_errors++; $display("FAIL reset_nib_addr got %h want 0", nib_addr); end
        n_checks++; if (level !== 3'd0) begin n_errors++; $display("FAIL reset_level got %0d want 0", level); end
    endtask

    task automatic test_sequence();
        logic [3:0] exp_nib [8];
        exp_nib = '{4'h0, 4'h0, 4'h1, 4'h1, 4'hC, 4'h4, 4'h0, 4'h3};
        mem[0] = 8'h00; mem[1] = 8'h11; mem[2] = 8'h4C; mem[3] = 8'h30;
        rst = 1'b1; nib_ready = 1'b1; tick();
        rst = 1'b0; settle();
        n_checks++; if (mem_enable_read !== 1'b1 || mem_addr !== 15'h0) begin n_errors++; $display("FAIL seq_first_fetch got en=%b addr=%h want en=1 addr=0", mem_enable_read, mem_addr); end
        n_checks++; if (nib_valid !== 1'b0) begin n_errors++; $display("FAIL seq_early_valid got %b want 0", nib_valid); end
        tick();
        for (int i = 0; i < 8; i++) begin
            settle();
            n_checks++; if (nib_valid !== 1'b1) begin n_errors++; $display("FAIL seq_valid[%0d] got %b want 1", i, nib_valid); end
            n_checks++; if (nib_data !== exp_nib[i]) begin n_errors++; $display("FAIL seq_data[%0d] got %h want %h", i, nib_data, exp_nib[i]); end
            n_checks++; if (nib_addr !== 16'(i)) begin n_errors++; $display("FAIL seq_addr[%0d] got %h want %h", i, nib_addr, i); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        rst = 1'b1; nib_ready = 1'b0; tick();
        rst = 1'b0;
        repeat (DEPTH + 3) tick();
        settle();
        n_checks++; if (level !== 3'(DEPTH)) begin n_errors++; $display("FAIL bp_level got %0d want %0d", level, DEPTH); end
        n_checks++; if (mem_enable_read !== 1'b0) begin n_errors++; $display("FAIL bp_en got %b want 0", mem_enable_read); end
        n_checks++; if (mem_addr !== 15'(DEPTH)) begin n_errors++; $display("FAIL bp_mem_addr got %h want %h", mem_addr, DEPTH); end
        nib_ready = 1'b1;
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            settle();
            n_checks++; if (nib_valid !== 1'b1 || nib_addr !== 16'(i) || nib_data !== mem_nib(i)) begin
                n_errors++; $display("FAIL bp_drain[%0d] got v=%b a=%h d=%h want v=1 a=%h d=%h", i, nib_valid, nib_addr, nib_data, i, mem_nib(i));
            end
            tick();
        end
    endtask

    task automatic test_redirect_even();
        nib_ready = 1'b0;
        repeat (DEPTH + 1) tick();
        redirect = 1'b1; redirect_addr = 16'h003C; nib_ready = 1'b1; settle();
        n_checks++; if (mem_enable_read !== 1'b0) begin n_errors++; $display("FAIL redir_en_suppress got %b want 0", mem_enable_read); end
        tick();
        redirect = 1'b0; settle();
        n_checks++; if (mem_enable_read !== 1'b1 || mem_addr !== 15'h001E) begin n_errors++; $display("FAIL redir_fetch got en=%b addr=%h want en=1 addr=001e", mem_enable_read, mem_addr); end
        n_checks++; if (nib_valid !== 1'b0 || level !== 3'd0) begin n_errors++; $display("FAIL redir_flushed got v=%b lvl=%0d want v=0 lvl=0", nib_valid, level); end
        tick(); settle();
        n_checks++; if (nib_valid !== 1'b1 || nib_addr !== 16'h003C || nib_data !== mem_nib(16'h3C)) begin
            n_errors++; $display("FAIL redir_even got v=%b a=%h d=%h want v=1 a=003c d=%h", nib_valid, nib_addr, nib_data, mem_nib(16'h3C));
        end
    endtask

    task automatic test_redirect_odd();
        redirect = 1'b1; redirect_addr = 16'h0051; nib_ready = 1'b1;
        tick();
        redirect = 1'b0;
        tick(); settle();
        n_checks++; if (nib_valid !== 1'b1 || nib_addr !== 16'h0051 || nib_data !== mem[16'h28][7:4]) begin
            n_errors++; $display("FAIL redir_odd_first got v=%b a=%h d=%h want v=1 a=0051 d=%h", nib_valid, nib_addr, nib_data, mem[16'h28][7:4]);
        end
        tick(); settle();
        n_checks++; if (nib_addr !== 16'h0052 || nib_data !== mem[16'h29][3:0]) begin
            n_errors++; $display("FAIL redir_odd_next got a=%h d=%h want a=0052 d=%h", nib_addr, nib_data, mem[16'h29][3:0]);
        end
    endtask

    task automatic test_bus_busy();
        int exp_na;
        redirect = 1'b1; redirect_addr = 16'h0100; nib_ready = 1'b1;
        tick();
        redirect = 1'b0;
        exp_na = 16'h0100;
        for (int c = 0; c < 12; c++) begin
            bus_busy = (c >= 2 && c <= 4);
            settle();
            if (bus_busy) begin
                n_checks++; if (mem_enable_read !== 1'b0 || mem_addr !== 15'h0082) begin n_errors++; $display("FAIL busy_hold[%0d] got en=%b addr=%h want en=0 addr=0082", c, mem_enable_read, mem_addr); end
            end
            if (c == 5) begin
                n_checks++; if (mem_enable_read !== 1'b1 || mem_addr !== 15'h0082) begin n_errors++; $display("FAIL busy_resume got en=%b addr=%h want en=1 addr=0082", mem_enable_read, mem_addr); end
            end
            n_checks++; if (nib_valid !== m_valid()) begin n_errors++; $display("FAIL busy_valid[%0d] got %b want %b", c, nib_valid, m_valid()); end
            if (m_valid()) begin
                n_checks++; if (nib_addr !== 16'(exp_na) || nib_data !== mem_nib(exp_na)) begin
                    n_errors++; $display("FAIL busy_stream[%0d] got a=%h d=%h want a=%h d=%h", c, nib_addr, nib_data, exp_na, mem_nib(exp_na));
                end
                exp_na++;
            end
            tick();
        end
        bus_busy = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        redirect = 1'b1; redirect_addr = 16'hFFFE; nib_ready = 1'b1;
        tick();
        redirect = 1'b0; settle();
        n_checks++; if (mem_enable_read !== 1'b1 || mem_addr !== 15'h7FFF) begin n_errors++; $display("FAIL wrap_fetch_top got en=%b addr=%h want en=1 addr=7fff", mem_enable_read, mem_addr); end
        tick(); settle();
        n_checks++; if (mem_addr !== 15'h0000) begin n_errors++; $display("FAIL wrap_fetch_zero got %h want 0000", mem_addr); end
        n_checks++; if (nib_addr !== 16'hFFFE || nib_data !== mem[15'h7FFF][3:0]) begin n_errors++; $display("FAIL wrap_nib_fffe got a=%h d=%h want a=fffe d=%h", nib_addr, nib_data, mem[15'h7FFF][3:0]); end
        tick(); settle();
        n_checks++; if (nib_addr !== 16'hFFFF || nib_data !== mem[15'h7FFF][7:4]) begin n_errors++; $display("FAIL wrap_nib_ffff got a=%h d=%h want a=ffff d=%h", nib_addr, nib_data, mem[15'h7FFF][7:4]); end
        tick(); settle();
        n_checks++; if (nib_addr !== 16'h0000 || nib_data !== mem[0][3:0]) begin n_errors++; $display("FAIL wrap_nib_0000 got a=%h d=%h want a=0000 d=%h", nib_addr, nib_data, mem[0][3:0]); end
        tick();
        rst = 1'b1;
        tick(); settle();
        n_checks++; if (mem_enable_read !== 1'b0 || mem_addr !== 15'h0 || nib_valid !== 1'b0 || nib_data !== 4'h0 || nib_addr !== 16'h0 || level !== 3'd0) begin
            n_errors++; $display("FAIL midreset got en=%b ma=%h v=%b d=%h na=%h lvl=%0d want all 0", mem_enable_read, mem_addr, nib_valid, nib_data, nib_addr, level);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        rst = 1'b1; tick(); rst = 1'b0;
        for (int c = 0; c < 800; c++) begin
            bus_busy      = ($urandom_range(0, 3) == 0);
            nib_ready     = ($urandom_range(0, 2) != 0);
            redirect      = ($urandom_range(0, 29) == 0);
            redirect_addr = 16'($urandom);
            rst           = ($urandom_range(0, 149) == 0);
            settle();
            n_checks++; if (mem_enable_read !== m_fetch_en() || mem_addr !== m_fetch) begin
                n_errors++; $display("FAIL rnd_fetch[%0d] got en=%b addr=%h want en=%b addr=%h", c, mem_enable_read, mem_addr, m_fetch_en(), m_fetch);
            end
            n_checks++; if (nib_valid !== m_valid() || nib_data !== m_data() || nib_addr !== {m_head, m_sel}) begin
                n_errors++; $display("FAIL rnd_nib[%0d] got v=%b d=%h a=%h want v=%b d=%h a=%h", c, nib_valid, nib_data, nib_addr, m_valid(), m_data(), {m_head, m_sel});
            end
            n_checks++; if (level !== 3'(m_q.size())) begin
                n_errors++; $display("FAIL rnd_level[%0d] got %0d want %0d", c, level, m_q.size());
            end
            tick();
        end
        rst = 1'b0; redirect = 1'b0; bus_busy = 1'b0;
    endtask

    initial begin
        for (int a = 0; a < 32768; a++) mem[a] = 8'($urandom);
        m_fetch = '0; m_head = '0; m_sel = 1'b0;
        test_reset();
        test_sequence();
        test_backpressure();
        test_redirect_even();
        test_redirect_odd();
        test_bus_busy();
        test_wrap_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/misao_fetch_queue.md
# misao_fetch_queue

Instruction prefetch queue between the byte-wide instruction memory port and the MISA-O decoder. Fetches sequential bytes into a small FIFO and hands them to the core one nibble per handshake, low nibble first, tagged with its nibble address. A redirect from branch/jump/JAL logic flushes the queue and restarts fetch at any nibble address. Data accesses own the shared memory port whenever the core asserts `bus_busy`.

## Interface
- `DEPTH`, 4: queue capacity in bytes; power of two, ≥2.
- `ADDR_W`, 15: byte address width of the memory port.

- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_enable_read`  out  1  fetch read strobe for this cycle.
- `mem_addr`  out  ADDR_W  fetch byte address; always driven from the fetch-address register.
- `mem_data_in`  in  8  read data; combinational memory, valid in the same cycle as the strobe.
- `bus_busy`  in  1  core data access owns the port this cycle; no fetch issued.
- `redirect`  in  1  flush and restart fetch.
- `redirect_addr`  in  ADDR_W+1  target nibble address {byte, nibble_sel}.
- `nib_valid`  out  1  `nib_data` holds the next instruction nibble.
- `nib_data`  out  4  current nibble; 0 when `nib_valid`=0.
- `nib_addr`  out  ADDR_W+1  nibble address of `nib_data` = {head_addr, sel}.
- `nib_ready`  in  1  decoder consumes the nibble this cycle.
- `level`  out  $clog2(DEPTH)+1  bytes currently held.

## Operation
- State: fetch_addr (ADDR_W), head_addr (ADDR_W), sel (1), byte FIFO (data only), count.
- Fetch: `mem_enable_read`=1 when !rst && !redirect && !bus_busy && count<DEPTH. On that edge, push `mem_data_in`, fetch_addr += 1, wrapping 0x7FFF→0x0000. Full blocks fetch even if a byte pops in the same cycle (no bypass).
- Output: `nib_valid`=(count≠0). `nib_data`=sel ? head[7:4] : head[3:0].
- Consume (`nib_valid && nib_ready`): sel=0 → sel=1. sel=1 → pop head byte, sel=0, head_addr += 1 with the same wrap. `nib_ready` without `nib_valid` is ignored.
- Push and pop in the same edge: count unchanged.
- Redirect is highest priority. Queue cleared and count=0. fetch_addr=head_addr=redirect_addr[ADDR_W:1]. sel=redirect_addr[0]. Same-cycle consume and fetch are suppressed (`mem_enable_read`=0). An odd target discards the low nibble of the first fetched byte.
- `bus_busy` together with redirect: redirect still applied.
- Reset: identical to a redirect to nibble address 0. Mid-operation reset discards queued bytes.

## Timing
- Reset values: `mem_enable_read`=0, `mem_addr`=0, `nib_valid`=0, `nib_data`=0, `nib_addr`=0, `level`=0.
- First cycle after `rst` deasserts: fetch byte 0. The following cycle: `nib_valid`=1, `nib_addr`=0.
- Redirect at edge N: fetch of target byte in cycle N+1 (if bus free), nib_valid in cycle N+2. Redirect-to-valid latency is 2 cycles.
- Fill rate is 1 byte/cycle and drain is ≤1 nibble/cycle. With `bus_busy` low, a continuously ready consumer never sees `nib_valid` drop after the first valid nibble.
- Each `bus_busy` cycle delays the fetch stream by exactly one cycle. No fetch is lost or duplicated.

## Structure
- `misao_pkg`: `ADDR_W`, `nib_addr_t` (ADDR_W+1 bits), `byte_t`, `nibble_t`, reset vector constant (0).
- Sub-module `misao_byte_fifo`: DEPTH×8 storage with push/pop/flush, count, full/empty.
- Address, sel and fetch control stay in the top module.

## Test plan
- Reset release, mem[0..3]=00,11,4C,30, `nib_ready`=1 → nibbles 0,0,1,1,C,4,0,3 with `nib_addr` 0..7 on consecutive cycles after the first valid.
- `nib_ready`=0 from reset → `level` saturates at DEPTH, `mem_enable_read` drops, `mem_addr`=DEPTH. Raise ready → no nibble skipped.
- Redirect to 0x003C (byte 0x1E, even) with a full queue → next valid nibble is mem[0x1E][3:0] in cycle N+2, `nib_addr`=0x003C.
- Redirect to 0x0051 (odd) → first nibble mem[0x28][7:4], `nib_addr`=0x0051, next `nib_addr`=0x0052.
- `bus_busy` high for 3 cycles during streaming → `mem_enable_read`=0 for those cycles, nibble sequence contiguous, fetch resumes at the correct byte.
- Redirect to 0xFFFE → fetches 0x7FFF then 0x0000, `nib_addr` wraps 0xFFFF→0x0000. Assert `rst` mid-stream → all outputs at reset values on the next cycle.
